// File: rtl/audio_pkg.sv
// Shared types and address helpers for the flash sample reader.
// Holds the FSM state encoding, flash geometry and wrap-around address stepping.
package audio_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_DATA = 2'd1,
    HALF0     = 2'd2,
    HALF1     = 2'd3
  } state_t;

  localparam int                      FLASH_ADDR_W   = 23;
  localparam logic [FLASH_ADDR_W-1:0] FLASH_END_ADDR = 23'h7FFFF;

  // Step one word in the requested direction, wrapping at 0 and end_addr by compare.
  function automatic logic [FLASH_ADDR_W-1:0] next_addr(
    input logic [FLASH_ADDR_W-1:0] addr,
    input logic                    reverse,
    input logic [FLASH_ADDR_W-1:0] end_addr
  );
    logic [FLASH_ADDR_W-1:0] result;
    if (reverse) begin
      result = (addr == '0) ? end_addr : addr - 1'b1;
    end else begin
      result = (addr == end_addr) ? '0 : addr + 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/flash_sample_reader.sv
// Reads 32-bit flash words over Avalon-MM and plays them out as two 8-bit samples,
// one per sample_tick, with pause, direction control, restart and underrun reporting.
module flash_sample_reader
  import audio_pkg::*;
#(
  parameter int                ADDR_W   = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] END_ADDR = FLASH_END_ADDR
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              enable,
  input  logic              reverse,
  input  logic              restart,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [7:0]        audio_sample,
  output logic              sample_valid,
  output logic              underrun
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       word_reg, word_next;
  logic              dir_reg, dir_next;
  logic              read_reg, read_next;
  logic [7:0]        sample_reg, sample_next;
  logic              valid_reg, valid_next;
  logic              underrun_reg, underrun_next;
  logic              discard_reg, discard_next;
  logic              restart_dir_reg, restart_dir_next;
  logic [ADDR_W-1:0] start_addr;
  logic              play_tick;

  assign start_addr = reverse ? END_ADDR : '0;
  assign play_tick  = sample_tick && enable && !restart;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= FETCH;
      addr_reg        <= '0;
      word_reg        <= '0;
      dir_reg         <= 1'b0;
      read_reg        <= 1'b0;
      sample_reg      <= '0;
      valid_reg       <= 1'b0;
      underrun_reg    <= 1'b0;
      discard_reg     <= 1'b0;
      restart_dir_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      word_reg        <= word_next;
      dir_reg         <= dir_next;
      read_reg        <= read_next;
      sample_reg      <= sample_next;
      valid_reg       <= valid_next;
      underrun_reg    <= underrun_next;
      discard_reg     <= discard_next;
      restart_dir_reg <= restart_dir_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    word_next        = word_reg;
    dir_next         = dir_reg;
    read_next        = read_reg;
    sample_next      = sample_reg;
    valid_next       = 1'b0;
    underrun_next    = underrun_reg;
    discard_next     = discard_reg;
    restart_dir_next = restart_dir_reg;

    if (play_tick && (state_reg == FETCH || state_reg == WAIT_DATA)) begin
      underrun_next = 1'b1;
    end

    case (state_reg)
      FETCH: begin
        if (!read_reg) begin
          // A restart before launch just retargets; launching now would use the stale address.
          if (restart) begin
            addr_next = start_addr;
          end else begin
            read_next = 1'b1;
            dir_next  = reverse;
          end
        end else begin
          if (restart) begin
            discard_next     = 1'b1;
            restart_dir_next = reverse;
          end
          if (!flash_mem_waitrequest) begin
            read_next  = 1'b0;
            state_next = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (restart) begin
          discard_next     = 1'b1;
          restart_dir_next = reverse;
        end
        if (flash_mem_readdatavalid) begin
          if (discard_reg || restart) begin
            addr_next    = (restart ? reverse : restart_dir_reg) ? END_ADDR : '0;
            discard_next = 1'b0;
            state_next   = FETCH;
          end else begin
            word_next  = flash_mem_readdata;
            state_next = HALF0;
          end
        end
      end
      HALF0: begin
        if (restart) begin
          addr_next  = start_addr;
          word_next  = '0;
          state_next = FETCH;
        end else if (play_tick) begin
          sample_next = dir_reg ? word_reg[31:24] : word_reg[15:8];
          valid_next  = 1'b1;
          state_next  = HALF1;
        end
      end
      HALF1: begin
        if (restart) begin
          addr_next  = start_addr;
          word_next  = '0;
          state_next = FETCH;
        end else if (play_tick) begin
          sample_next = dir_reg ? word_reg[15:8] : word_reg[31:24];
          valid_next  = 1'b1;
          addr_next   = next_addr(addr_reg, reverse, END_ADDR);
          state_next  = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign flash_mem_read       = read_reg;
  assign flash_mem_address    = addr_reg;
  assign flash_mem_byteenable = 4'b1111;
  assign audio_sample         = sample_reg;
  assign sample_valid         = valid_reg;
  assign underrun             = underrun_reg;

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Downstream consumer of the clock-synchroniser's single-cycle `edgedetect` pulse: one pulse = one audio sample request, at the divided sample rate (e.g. 22 kHz) in the CLOCK_50 domain.
- Fetches 32-bit words from on-board flash over an Avalon-MM read master, splits each word into two 8-bit samples and presents one sample per tick to the audio output path.
- Supports play/pause, forward/reverse direction and restart, with wrap-around at the address bounds.

Parameters:
- ADDR_W, 23, flash word-address width.
- END_ADDR, 23'h7FFFF, last valid word address; playback covers 0..END_ADDR inclusive.

Ports:
- CLOCK_50  input  1  system clock (50 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- sample_tick  input  1  one-cycle pulse from clock_sync (`edgedetect`), already synchronous to CLOCK_50.
- enable  input  1  1 = play, 0 = pause.
- reverse  input  1  0 = forward, 1 = backward; sampled only when the next address is computed.
- restart  input  1  one-cycle pulse; jump to start of track for the current direction.
- flash_mem_read  output  1  Avalon read request.
- flash_mem_waitrequest  input  1  Avalon stall.
- flash_mem_address  output  ADDR_W  word address.
- flash_mem_byteenable  output  4  constant 4'b1111.
- flash_mem_readdata  input  32  read data.
- flash_mem_readdatavalid  input  1  read data qualifier.
- audio_sample  output  8  current signed sample, held between ticks.
- sample_valid  output  1  one-cycle pulse when audio_sample updates.
- underrun  output  1  sticky flag: a tick arrived with no buffered data.

Behaviour:
- Reset (async assert, sync release) forces:
  - flash_mem_read=0, flash_mem_address=0, audio_sample=0, sample_valid=0, underrun=0;
  - word buffer=0; state=FETCH.
- FSM states: FETCH, WAIT_DATA, HALF0, HALF1.
- FETCH:
  - Assert flash_mem_read with a stable address.
  - While waitrequest=1, hold read and address.
  - On the cycle read=1 and waitrequest=0, deassert read next cycle and go to WAIT_DATA.
  - Never drop read while waitrequest=1.
- WAIT_DATA:
  - On readdatavalid=1, latch readdata into the word buffer and go to HALF0.
  - Exactly one read is outstanding at a time.
- Sample mapping (half = 16-bit field; sample = upper byte of that field):
  - Forward: HALF0 emits readdata[15:8], HALF1 emits readdata[31:24].
  - Reverse: HALF0 emits [31:24], HALF1 emits [15:8].
  - Direction is latched at the FETCH launch for that word.
- HALF0:
  - On sample_tick and enable=1, load audio_sample next cycle, pulse sample_valid for 1 cycle, go to HALF1.
- HALF1:
  - On sample_tick and enable=1, emit the second sample, compute the next address, go to FETCH.
- Latency: tick to audio_sample/sample_valid is exactly 1 cycle.
- Address arithmetic:
  - Forward: END_ADDR+1 wraps to 0.
  - Reverse: 0-1 wraps to END_ADDR.
  - Computed in ADDR_W bits with an explicit compare, never relying on natural overflow.
- Pause (enable=0):
  - Ticks are ignored; no underrun flag is set.
  - An outstanding Avalon transaction still completes; the FSM then waits in HALF0/HALF1.
  - audio_sample holds its value.
- Underrun:
  - Condition: sample_tick=1 and enable=1 while in FETCH or WAIT_DATA.
  - Set underrun=1 (sticky until reset); audio_sample holds its value; no sample_valid.
- Restart:
  - Address becomes 0 (reverse=0) or END_ADDR (reverse=1).
  - From HALF0/HALF1: discard the buffer and go straight to FETCH.
  - During FETCH with waitrequest=1, or during WAIT_DATA: finish the current transaction, discard its data (no emission), then FETCH the new address.
  - restart has priority over a simultaneous sample_tick; that tick is dropped and does not set underrun.
- Direction change mid-word: takes effect at the next address computation only.
- Reset mid-transaction: read drops immediately. A late readdatavalid after reset is ignored because the state is FETCH.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum typedef (FETCH, WAIT_DATA, HALF0, HALF1);
  - FLASH_ADDR_W=23 and FLASH_END_ADDR=23'h7FFFF constants;
  - a function next_addr(addr, reverse) implementing the wrap rules.
- No sub-module: one FSM plus a datapath register file. The Avalon master stays inline because it is only two states.

Test Plan:
- Reset, then waitrequest=0, readdatavalid 2 cycles after read, readdata=32'hA1B2_C3D4, forward, two ticks → address 0 read once; audio_sample=8'hC3 then 8'hA1, each with a 1-cycle sample_valid; next read at address 1.
- Same word with reverse=1 after restart → address=END_ADDR; emits 8'hA1 then 8'hC3; next read at address 23'h7FFFE.
- Wrap-around: force forward play to address 23'h7FFFF and consume both halves → next flash_mem_address=0. Reverse from 0 → next address=23'h7FFFF.
- waitrequest held high 5 cycles → read and address stable all 5 cycles; read deasserts the cycle after waitrequest falls; exactly one request counted.
- Tick issued while WAIT_DATA (readdatavalid delayed 10 cycles) → underrun=1 and stays 1; audio_sample unchanged; no sample_valid. Tick with enable=0 → no underrun, no output change.
- restart pulsed during WAIT_DATA (forward, address 5) → data for address 5 discarded with no sample_valid; next read issued at address 0; first emitted sample comes from word 0.
